// File: rtl/pipelined_alu_if.sv
// Request/response bundle for pipelined_alu: a valid/ready request channel
// carrying the operation, and a valid/ready result channel carrying result and flags.
interface pipelined_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             sat_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_zero;
    logic             flag_carry;
    logic             flag_ovf;

    modport master (
        output in_valid, op_code, operand_a, operand_b, sat_mode, out_ready,
        input  in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf
    );

    modport slave (
        input  in_valid, op_code, operand_a, operand_b, sat_mode, out_ready,
        output in_ready, out_valid, result, flag_zero, flag_carry, flag_ovf
    );
endinterface

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU: stage 1 registers the request, stage 2 registers result and flags.
// Optional signed saturation of ADD/SUB is enabled by defining PIPELINED_ALU_SAT_EN.
module pipelined_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    pipelined_alu_if.slave     alu
);
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_SLL = 3'b110,
        OP_SRL = 3'b111
    } op_t;

    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

    logic                    vld_p1;
    op_t                     op_p1;
    logic signed [WIDTH-1:0] a_p1;
    logic signed [WIDTH-1:0] b_p1;

    logic                    vld_p2;
    logic        [WIDTH-1:0] res_p2;
    logic                    zero_p2;
    logic                    carry_p2;
    logic                    ovf_p2;

    logic                    adv_p1;
    logic                    adv_p2;
    logic        [WIDTH:0]   sum_w;
    logic        [WIDTH:0]   diff_w;
    logic        [WIDTH-1:0] res_c;
    logic                    carry_c;
    logic                    ovf_c;

`ifdef PIPELINED_ALU_SAT_EN
    logic                    sat_p1;

    // Clamp value for a signed overflow whose true sign follows operand a.
    function automatic logic [WIDTH-1:0] sat_limit(input logic neg);
        sat_limit = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction
`endif

    assign adv_p2       = !vld_p2 || alu.out_ready;
    assign adv_p1       = !vld_p1 || adv_p2;
    assign alu.in_ready = adv_p1;

    // ---- stage 1: capture request ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (adv_p1) begin
            vld_p1 <= alu.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (adv_p1 && alu.in_valid) begin
            op_p1 <= op_t'(alu.op_code);
            a_p1  <= alu.operand_a;
            b_p1  <= alu.operand_b;
`ifdef PIPELINED_ALU_SAT_EN
            sat_p1 <= alu.sat_mode;
`endif
        end
    end

    assign sum_w  = {1'b0, a_p1} + {1'b0, b_p1};
    assign diff_w = {1'b0, a_p1} + {1'b0, ~b_p1} + ONE_W;

    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        unique case (op_p1)
            OP_ADD: begin
                res_c   = sum_w[WIDTH-1:0];
                carry_c = sum_w[WIDTH];
                ovf_c   = (a_p1[WIDTH-1] == b_p1[WIDTH-1]) && (sum_w[WIDTH-1] != a_p1[WIDTH-1]);
            end
            OP_SUB: begin
                res_c   = diff_w[WIDTH-1:0];
                carry_c = diff_w[WIDTH];
                ovf_c   = (a_p1[WIDTH-1] != b_p1[WIDTH-1]) && (diff_w[WIDTH-1] != a_p1[WIDTH-1]);
            end
            OP_AND:  res_c = a_p1 & b_p1;
            OP_OR:   res_c = a_p1 | b_p1;
            OP_XOR:  res_c = a_p1 ^ b_p1;
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, (a_p1 < b_p1)};
            OP_SLL:  res_c = a_p1 << b_p1[SHAMT_W-1:0];
            OP_SRL:  res_c = a_p1 >> b_p1[SHAMT_W-1:0];
            default: res_c = '0;
        endcase
`ifdef PIPELINED_ALU_SAT_EN
        if (sat_p1 && ovf_c && (op_p1 == OP_ADD || op_p1 == OP_SUB)) begin
            res_c = sat_limit(a_p1[WIDTH-1]);
        end
`endif
    end

    // ---- stage 2: register result and flags ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2   <= 1'b0;
            res_p2   <= '0;
            zero_p2  <= 1'b0;
            carry_p2 <= 1'b0;
            ovf_p2   <= 1'b0;
        end else if (adv_p2) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                res_p2   <= res_c;
                zero_p2  <= (res_c == '0);
                carry_p2 <= carry_c;
                ovf_p2   <= ovf_c;
            end
        end
    end

    assign alu.out_valid  = vld_p2;
    assign alu.result     = res_p2;
    assign alu.flag_zero  = zero_p2;
    assign alu.flag_carry = carry_p2;
    assign alu.flag_ovf   = ovf_p2;
endmodule

// File: tb/tb_pipelined_alu.sv
// Directed + random bench for pipelined_alu (WIDTH=32) with a scoreboard queue of
// expected results filled on request transfer and drained on result transfer.
module tb_pipelined_alu;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, SLT = 3'd5, SLL = 3'd6, SRL = 3'd7;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_out = 0;
    exp_t sb[$];

    pipelined_alu_if #(.WIDTH(32)) bus ();

    pipelined_alu #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .alu (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic sat);
        exp_t   e;
        longint sa, sb_, s;
        e   = '0;
        sa  = longint'($signed(a));
        sb_ = longint'($signed(b));
        s   = 0;
        case (op)
            ADD: begin
                s     = sa + sb_;
                e.res = a + b;
                e.c   = ({32'd0, a} + {32'd0, b}) > 64'h0000_0000_FFFF_FFFF;
                e.o   = (s != longint'($signed(e.res)));
            end
            SUB: begin
                s     = sa - sb_;
                e.res = a - b;
                e.c   = (a >= b);
                e.o   = (s != longint'($signed(e.res)));
            end
            AND_: e.res = a & b;
            OR_:  e.res = a | b;
            XOR_: e.res = a ^ b;
            SLT:  e.res = (sa < sb_) ? 32'd1 : 32'd0;
            SLL:  e.res = a << b[4:0];
            default: e.res = a >> b[4:0];
        endcase
`ifdef PIPELINED_ALU_SAT_EN
        if (sat && e.o && (op == ADD || op == SUB))
            e.res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
        if (sat) e.res = e.res;
`endif
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    // Scoreboard: pop on result transfer, push on request transfer.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                exp_t e;
                n_total++;
                assert (sb.size() != 0) n_pass++;
                else $error("FAIL sb_underflow observed=%0d expected=nonzero", sb.size());
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_result", {32'd0, bus.result}, {32'd0, e.res});
                    chk("sb_zero",   {63'd0, bus.flag_zero},  {63'd0, e.z});
                    chk("sb_carry",  {63'd0, bus.flag_carry}, {63'd0, e.c});
                    chk("sb_ovf",    {63'd0, bus.flag_ovf},   {63'd0, e.o});
                end
                n_out++;
            end
            if (bus.in_valid && bus.in_ready)
                sb.push_back(model(bus.op_code, bus.operand_a, bus.operand_b, bus.sat_mode));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sat);
        bus.in_valid  = 1'b1;
        bus.op_code   = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.sat_mode  = sat;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'h0000_0000;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h7FFF_FFFF;
            3: pick = 32'h8000_0000;
            default: pick = $urandom;
        endcase
    endfunction

    logic [2:0]  s_op[8];
    logic [31:0] s_a[8];
    logic [31:0] s_b[8];

    initial begin
        int          base;
        int          acc;
        logic [31:0] held;
        bus.in_valid  = 1'b0;
        bus.op_code   = 3'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.sat_mode  = 1'b0;
        bus.out_ready = 1'b1;

        // Reset takes effect without any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_result",    {32'd0, bus.result},    64'd0);
        chk("rst_flags",     {61'd0, bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 64'd0);
        chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
        step();
        step();
        rst = 1'b0;
        chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

        // ADD wrap to zero, latency of two edges.
        drive(ADD, 32'hFFFF_FFFF, 32'd1, 1'b0);
        step();
        bus.in_valid = 1'b0;
        chk("lat1_out_valid", {63'd0, bus.out_valid}, 64'd0);
        step();
        chk("lat2_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("add_wrap_result", {32'd0, bus.result}, 64'd0);
        chk("add_wrap_flags", {61'd0, bus.flag_zero, bus.flag_carry, bus.flag_ovf}, 64'b110);

        // Saturating ADD request.
        drive(ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
        step();
        bus.in_valid = 1'b0;
        step();
`ifdef PIPELINED_ALU_SAT_EN
        chk("sat_add_result", {32'd0, bus.result}, 64'h7FFF_FFFF);
`else
        chk("sat_add_result", {32'd0, bus.result}, 64'h8000_0000);
`endif
        chk("sat_add_ovf", {63'd0, bus.flag_ovf}, 64'd1);
        step();

        // Eight back-to-back operations.
        s_op = '{SUB, AND_, OR_, XOR_, SLT, SLL, SRL, ADD};
        s_a  = '{32'd10, 32'hF0F0_1234, 32'h0F00_0001, 32'hAAAA_5555, 32'hFFFF_FFFF,
                 32'd1, 32'h8000_0000, 32'd5};
        s_b  = '{32'd3, 32'h0FF0_FFFF, 32'hF000_0010, 32'hFFFF_0000, 32'd0,
                 32'd31, 32'd31, 32'd7};
        base = n_out;
        for (int i = 0; i < 8; i++) begin
            drive(s_op[i], s_a[i], s_b[i], 1'b0);
            chk("stream_in_ready", {63'd0, bus.in_ready}, 64'd1);
            if (i == 6) chk("stream_slt", {32'd0, bus.result}, 64'd1);
            if (i == 7) chk("stream_sll", {32'd0, bus.result}, 64'h8000_0000);
            step();
        end
        bus.in_valid = 1'b0;
        chk("stream_srl", {32'd0, bus.result}, 64'd1);
        step();
        chk("stream_count7", 64'(n_out - base), 64'd7);
        step();
        chk("stream_count8", 64'(n_out - base), 64'd8);

        // Backpressure: two accepted, then stall with stable output.
        bus.out_ready = 1'b0;
        acc  = 0;
        held = '0;
        base = n_out;
        for (int k = 0; k < 5; k++) begin
            drive(XOR_, 32'h1111_0000 + 32'(k), 32'h0000_FFFF, 1'b0);
            if (bus.in_ready) acc++;
            if (k == 2) held = bus.result;
            step();
        end
        bus.in_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd2);
        chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("bp_result_stable", {32'd0, bus.result}, {32'd0, held});
        bus.out_ready = 1'b1;
        step();
        chk("bp_in_ready_back", {63'd0, bus.in_ready}, 64'd1);
        step();
        chk("bp_drained", 64'(n_out - base), 64'd2);

        // Reset with two operations in flight.
        drive(ADD, 32'd1, 32'd2, 1'b0);
        step();
        drive(OR_, 32'hDEAD_0000, 32'h0000_BEEF, 1'b0);
        step();
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        sb.delete();
        #1;
        chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("midrst_result", {32'd0, bus.result}, 64'd0);
        chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("no_stale_out_valid", {63'd0, bus.out_valid}, 64'd0);
        end
        drive(SUB, 32'd5, 32'd7, 1'b0);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("post_rst_lat_valid", {63'd0, bus.out_valid}, 64'd1);
        chk("post_rst_sub", {32'd0, bus.result}, 64'hFFFF_FFFE);

        // Random traffic with random backpressure.
        for (int k = 0; k < 60; k++) begin
            bus.in_valid  = $urandom_range(0, 3) != 0;
            bus.op_code   = 3'($urandom_range(0, 7));
            bus.operand_a = pick();
            bus.operand_b = pick();
            bus.sat_mode  = $urandom_range(0, 1) != 0;
            bus.out_ready = $urandom_range(0, 2) != 0;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && (sb.size() != 0 || bus.out_valid); k++) step();
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", {63'd0, bus.out_valid}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
